// File: rtl/sync_cnt_seq_ctrl_pkg.sv
// Shared constants, state encoding and the terminal-value helper for the
// sync_cnt_seq_ctrl counter controller and its datapath.
package sync_cnt_seq_ctrl_pkg;

   localparam int          W       = 3;
   localparam logic [W-1:0] DEF_MOD = 3'd7;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_PAUSED = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_RUN    = ST_RUN,
      S_PAUSED = ST_PAUSED
   } state_t;

   // A programmed terminal value of zero selects the default modulus.
   function automatic logic [W-1:0] eff_mod(input logic [W-1:0] v);
      return (v == '0) ? DEF_MOD : v;
   endfunction

endpackage

// File: rtl/sync_cnt_core.sv
// W-bit falling-edge binary counter; CLR beats EN, one edge latency, no backpressure.
module sync_cnt_core
   import sync_cnt_seq_ctrl_pkg::*;
(
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         EN,
   input  logic         CLR,
   output logic [W-1:0] Q
);

   always_ff @(negedge CLK) begin
      if (!RST_N)
         Q <= '0;
      else if (CLR)
         Q <= '0;
      else if (EN)
         Q <= Q + W'(1);
   end

endmodule

// File: rtl/sync_cnt_seq_ctrl.sv
// Run controller turning sync_cnt_core into a one-shot or continuous modulo-N timer;
// all outputs registered on the falling edge, one edge from input to effect, no backpressure.
module sync_cnt_seq_ctrl
   import sync_cnt_seq_ctrl_pkg::*;
(
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         START,
   input  logic         STOP,
   input  logic         PAUSE,
   input  logic         MODE,
   input  logic [W-1:0] MOD_VAL,
   output logic [W-1:0] Q,
   output logic         RUN,
   output logic         TC,
   output logic         DONE
);

   state_t       state;
   logic [W-1:0] mod_r;
   logic         mode_r;
   logic         en;
   logic         clr;

   // Counter controls are decoded from the current state so Q moves on the
   // same edge as the state transition that requests it.
   always_comb begin
      en  = 1'b0;
      clr = 1'b0;
      case (state)
         S_IDLE:   clr = START && !STOP && !PAUSE;
         S_RUN: begin
            if (STOP)
               clr = 1'b1;
            else if (!PAUSE) begin
               if (Q == mod_r)
                  clr = 1'b1;
               else
                  en = 1'b1;
            end
         end
         S_PAUSED: clr = STOP;
         default:  clr = 1'b1;
      endcase
   end

   sync_cnt_core u_core (
      .CLK   (CLK),
      .RST_N (RST_N),
      .EN    (en),
      .CLR   (clr),
      .Q     (Q)
   );

   always_ff @(negedge CLK) begin
      if (!RST_N) begin
         state  <= S_IDLE;
         RUN    <= 1'b0;
         TC     <= 1'b0;
         DONE   <= 1'b0;
         mod_r  <= DEF_MOD;
         mode_r <= 1'b0;
      end else begin
         TC   <= 1'b0;
         DONE <= 1'b0;
         case (state)
            S_IDLE: begin
               if (START && !STOP && !PAUSE) begin
                  mod_r  <= eff_mod(MOD_VAL);
                  mode_r <= MODE;
                  RUN    <= 1'b1;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               if (STOP) begin
                  RUN   <= 1'b0;
                  state <= S_IDLE;
               end else if (PAUSE) begin
                  state <= S_PAUSED;
               end else if (Q == mod_r) begin
                  TC <= 1'b1;
                  if (!mode_r) begin
                     RUN   <= 1'b0;
                     DONE  <= 1'b1;
                     state <= S_IDLE;
                  end
               end
            end
            S_PAUSED: begin
               if (STOP) begin
                  RUN   <= 1'b0;
                  state <= S_IDLE;
               end else if (!PAUSE) begin
                  state <= S_RUN;
               end
            end
            default: begin
               RUN   <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
